dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data-memory port (`dmem`) between the RV32I core's load/store interface and a secondary master: the test loader / debug port that preloads and inspects data memory. It sits between `riscv`/loader and `dmem`, and serialises accesses through a three-state FSM with round-robin priority. Every transaction ends with a per-master completion strobe. Read data is registered before it is returned.

## Interface
- `XLEN`, 32, data/address/mask width (matches `` `XLEN``)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (0 = in reset)
- `m0_req`  in  1  master 0 (core) request; held with payload until `m0_gnt`
- `m0_we`  in  1  master 0 write enable (1 = store, 0 = load)
- `m0_addr`  in  XLEN  master 0 byte address
- `m0_wdata`  in  XLEN  master 0 store data
- `m0_mask`  in  XLEN  master 0 byte/bit write mask
- `m0_gnt`  out  1  one-cycle pulse: master 0 request accepted
- `m0_done`  out  1  one-cycle pulse: master 0 transaction complete
- `m0_rdata`  out  XLEN  master 0 load result, valid with `m0_done`
- `m1_*`  same set as `m0_*`, for master 1 (loader/debug)
- `mem_we`  out  1  to `dmem` write enable
- `mem_addr`  out  XLEN  to `dmem` address
- `mem_wdata`  out  XLEN  to `dmem` write data
- `mem_mask`  out  XLEN  to `dmem` mask
- `mem_rdata`  in  XLEN  from `dmem`, combinational read of `mem_addr`

## Operation
- FSM states: IDLE, ACCESS, RESP. Encoding is free. Reset state is IDLE.
- IDLE:
  - Requests are sampled only in this state.
  - If any `mX_req` = 1, select a winner and latch its `we/addr/wdata/mask` plus a 1-bit owner id, then go to ACCESS.
  - With no request, stay in IDLE.
- Winner selection:
  - A single requester wins.
  - If both request, the master named by priority pointer `rr` wins.
- `rr` rules:
  - Reset value 0 (master 0 first).
  - On every grant, `rr` moves to the other master.
- ACCESS (exactly 1 cycle):
  - `mem_*` are driven from the latched registers; `mem_we` = latched `we`.
  - The owner's `mX_gnt` = 1.
  - At the closing edge, capture `mem_rdata` into the owner's `mX_rdata` register (loads only; stores leave it unchanged), then go to RESP.
- RESP (exactly 1 cycle):
  - Owner's `mX_done` = 1; then go to IDLE.
  - The requester must deassert `req` or change payload during RESP. A `req` still high in the following IDLE is a new transaction.
- Outside ACCESS:
  - `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `mem_mask` hold their last latched values; they are don't-care, but must not glitch `mem_we`.
- Non-owner `gnt`/`done` are always 0. `gnt` and `done` are never high for both masters at once.
- `mX_rdata` holds its value until that master's next load completes.
- Payload is passed through unmodified. No alignment checks; `dmem` applies the mask.
- Reset values:
  - State IDLE, `rr` = 0, all latches 0.
  - `mem_we` = 0, `mem_addr`/`mem_wdata`/`mem_mask` = 0.
  - `m0/m1_gnt` = 0, `m0/m1_done` = 0, `m0/m1_rdata` = 0.

## Timing
- Request seen high in IDLE at edge N:
  - ACCESS in cycle N+1: `gnt` high, memory written at edge N+2 if store.
  - RESP in cycle N+2: `done` high, `rdata` valid.
  - Back to IDLE in cycle N+3.
- Latency from request to `done` is 2 cycles. Peak throughput is one transaction per 3 cycles.
- Two waiting masters are serviced alternately; the worst-case wait for a held request is 3 cycles.
- `gnt` and `done` are registered-state decodes, with no combinational path from `req`.
- Reset asserted (`reset` = 0) at any point:
  - All outputs clear immediately, without waiting for a clock edge.
  - `mem_we` drops within the same cycle, so an in-flight store is abandoned; it must not reach `dmem`.
  - The pending transaction is discarded; no `done` is issued.
- Reset release: the first edge with `reset` = 1 may accept a request.

## Test plan
- Isolated load: `dmem[0x64]` = 0x19; `m0_req` = 1, `m0_we` = 0, `m0_addr` = 0x64 → `m0_gnt` one cycle later; `m0_done` with `m0_rdata` = 0x19 the next cycle; `m1_*` stays 0.
- Store via loader: `m1_we` = 1, `m1_addr` = 0x64, `m1_wdata` = 25, `m1_mask` = 0xFFFFFFFF → `mem_we` high for exactly one cycle with `mem_addr` = 0x64 and `mem_wdata` = 0x19; `m1_done` the following cycle; readback through m0 returns 0x19.
- Simultaneous first request after reset: both request (m0 load 0x0, m1 load 0x4) → m0 granted in cycle 1; m1 granted in cycle 4; done pulses in cycles 2 and 5.
- Continuous contention: both masters hold `req` for 12 cycles → grant order m0, m1, m0, m1 at a 3-cycle spacing; never two `gnt` in one cycle.
- Reset mid-store: assert `reset` = 0 during ACCESS of an m0 store to 0x10 → `mem_we` drops immediately; `dmem[0x10]` is unchanged; no `m0_done`; after release, state is IDLE and `rr` = 0.
- Idle: no requests for 20 cycles → `mem_we` = 0 and all `gnt`/`done` = 0 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core (m0) and the loader/debug port (m1).
// Each access runs IDLE -> ACCESS -> RESP; strobes, memory write enable and read data are registered.
module dmem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    input  logic [XLEN-1:0] m0_mask,
    output logic            m0_gnt,
    output logic            m0_done,
    output logic [XLEN-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    input  logic [XLEN-1:0] m1_mask,
    output logic            m1_gnt,
    output logic            m1_done,
    output logic [XLEN-1:0] m1_rdata,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_mask,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rr;
    logic              r_owner;
    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_mask;
    logic [XLEN-1:0]   r_m0_rdata;
    logic [XLEN-1:0]   r_m1_rdata;
    logic              r_m0_gnt;
    logic              r_m1_gnt;
    logic              r_m0_done;
    logic              r_m1_done;
    logic              r_mem_we;

    logic              w_any_req;
    logic              w_accept;
    logic              w_win;
    logic              w_win_we;
    logic              w_m0_gnt_nxt;
    logic              w_m1_gnt_nxt;
    logic              w_m0_done_nxt;
    logic              w_m1_done_nxt;
    logic              w_mem_we_nxt;

    assign w_any_req = m0_req | m1_req;
    assign w_accept  = (r_state == ST_IDLE) && w_any_req;
    assign w_win_we  = w_win ? m1_we : m0_we;

    // Winner: lone requester wins, a tie goes to the master named by r_rr.
    always_comb begin
        w_win = 1'b0;
        if (m0_req && m1_req) begin
            w_win = r_rr;
        end else if (m1_req) begin
            w_win = 1'b1;
        end else begin
            w_win = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: requests are only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes, so they line up with ACCESS/RESP.
    always_comb begin
        w_m0_gnt_nxt  = 1'b0;
        w_m1_gnt_nxt  = 1'b0;
        w_m0_done_nxt = 1'b0;
        w_m1_done_nxt = 1'b0;
        w_mem_we_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_m0_gnt_nxt = w_accept && !w_win;
                w_m1_gnt_nxt = w_accept && w_win;
                w_mem_we_nxt = w_accept && w_win_we;
            end
            ST_ACCESS: begin
                w_m0_done_nxt = !r_owner;
                w_m1_done_nxt = r_owner;
            end
            ST_RESP: begin
                w_mem_we_nxt = 1'b0;
            end
            default: begin
                w_mem_we_nxt = 1'b0;
            end
        endcase
    end

    // Payload latch; r_rr points away from the master just granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr    <= 1'b0;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= {XLEN{1'b0}};
            r_wdata <= {XLEN{1'b0}};
            r_mask  <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_rr    <= ~w_win;
            r_owner <= w_win;
            r_we    <= w_win_we;
            r_addr  <= w_win ? m1_addr  : m0_addr;
            r_wdata <= w_win ? m1_wdata : m0_wdata;
            r_mask  <= w_win ? m1_mask  : m0_mask;
        end
    end

    // Registered handshake strobes and memory write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m0_gnt  <= 1'b0;
            r_m1_gnt  <= 1'b0;
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
            r_mem_we  <= 1'b0;
        end else begin
            r_m0_gnt  <= w_m0_gnt_nxt;
            r_m1_gnt  <= w_m1_gnt_nxt;
            r_m0_done <= w_m0_done_nxt;
            r_m1_done <= w_m1_done_nxt;
            r_mem_we  <= w_mem_we_nxt;
        end
    end

    // Load data capture at the end of ACCESS; stores leave the owner's rdata untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m0_rdata <= {XLEN{1'b0}};
            r_m1_rdata <= {XLEN{1'b0}};
        end else if ((r_state == ST_ACCESS) && !r_we) begin
            if (r_owner) begin
                r_m1_rdata <= mem_rdata;
            end else begin
                r_m0_rdata <= mem_rdata;
            end
        end
    end

    assign m0_gnt    = r_m0_gnt;
    assign m1_gnt    = r_m1_gnt;
    assign m0_done   = r_m0_done;
    assign m1_done   = r_m1_done;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_mask  = r_mask;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected completions, a monitor pops them on done.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m0_mask, m1_addr, m1_wdata, m1_mask;
    logic        m0_gnt, m0_done, m1_gnt, m1_done, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_mask, mem_rdata;

    logic [31:0] dmem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'd0;

    typedef struct packed {
        logic        m;
        logic        ld;
        logic [31:0] rd;
    } exp_t;

    exp_t  sb[$];
    logic  glog_m[$];
    int    glog_c[$];
    int    gnt_cyc[2];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    int    we_cnt = 0;

    dmem_arbiter #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_mask(m0_mask),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_mask(m1_mask),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: combinational read, masked write on the clock edge.
    always @(posedge clk) begin
        if (pl_en) begin
            dmem[pl_idx] <= pl_data;
        end else if (mem_we) begin
            dmem[mem_addr[7:2]] <= (dmem[mem_addr[7:2]] & ~mem_mask) | (mem_wdata & mem_mask);
        end
    end
    assign mem_rdata = dmem[mem_addr[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: owns the scoreboard pops and the grant log.
    initial begin
        exp_t e;
        logic m;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (mem_we) begin
                    we_cnt++;
                    chk("mem_addr_range", {8'd0, mem_addr[31:8]}, 32'd0);
                end
                if (m0_gnt || m1_gnt) begin
                    chk("gnt_onehot", {31'd0, m0_gnt & m1_gnt}, 32'd0);
                    m = m1_gnt;
                    gnt_cyc[m] = cyc;
                    glog_m.push_back(m);
                    glog_c.push_back(cyc);
                end
                if (m0_done || m1_done) begin
                    done_cnt++;
                    chk("done_onehot", {31'd0, m0_done & m1_done}, 32'd0);
                    m = m1_done;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: done from m%0d, expected none", m);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_owner", {31'd0, m}, {31'd0, e.m});
                        chk("sb_done_latency", 32'(cyc - gnt_cyc[m]), 32'd1);
                        if (e.ld) begin
                            chk("sb_rdata", m ? m1_rdata : m0_rdata, e.rd);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pl_en = 1'b1;
        pl_idx = idx;
        pl_data = data;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // Issue one request, wait (bounded) for its grant, drop req during RESP.
    task automatic xfer(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mask, input int exp_lat);
        int start;
        bit got;
        if (m == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_mask = mask;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_mask = mask;
        end
        start = cyc;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_gnt) || (m == 1 && m1_gnt)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: m%0d got no grant within 20 cycles", m);
        end else begin
            chk("gnt_latency", 32'(cyc - start), 32'(exp_lat));
            if (we) begin
                chk("store_mem_we", {31'd0, mem_we}, 32'd1);
                chk("store_mem_addr", mem_addr, addr);
                chk("store_mem_wdata", mem_wdata, wdata);
                chk("store_mem_mask", mem_mask, mask);
            end
        end
        @(posedge clk);
        #1;
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int dc;
        int start;
        bit got;
        reset = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_mask = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_mask = 32'd0;
        for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);
        preload(6'd0,  32'h1111_0000);
        preload(6'd1,  32'h2222_0004);
        preload(6'd4,  32'hCAFE_0010);
        preload(6'd25, 32'h0000_0019);
        preload(6'd26, 32'h1234_5678);

        // Reset state
        chk("rst_strobes", {27'd0, mem_we, m0_gnt, m0_done, m1_gnt, m1_done}, 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;
        step(2);

        // Simultaneous first request after reset: m0 then m1
        sb.push_back('{m: 1'b0, ld: 1'b1, rd: 32'h1111_0000});
        sb.push_back('{m: 1'b1, ld: 1'b1, rd: 32'h2222_0004});
        fork
            xfer(0, 1'b0, 32'h0, 32'h0, 32'h0, 1);
            xfer(1, 1'b0, 32'h4, 32'h0, 32'h0, 4);
        join
        step(2);
        chk("sim_done_count", 32'(done_cnt), 32'd2);

        // Isolated load
        sb.push_back('{m: 1'b0, ld: 1'b1, rd: 32'h0000_0019});
        xfer(0, 1'b0, 32'h64, 32'h0, 32'h0, 1);
        step(2);
        chk("m1_rdata_held", m1_rdata, 32'h2222_0004);

        // Store via loader, then readback through m0
        w0 = we_cnt;
        sb.push_back('{m: 1'b1, ld: 1'b0, rd: 32'h0});
        xfer(1, 1'b1, 32'h64, 32'd25, 32'hFFFF_FFFF, 1);
        step(2);
        chk("store_we_cycles", 32'(we_cnt - w0), 32'd1);
        chk("store_keeps_m1_rdata", m1_rdata, 32'h2222_0004);
        sb.push_back('{m: 1'b0, ld: 1'b1, rd: 32'h0000_0019});
        xfer(0, 1'b0, 32'h64, 32'h0, 32'h0, 1);
        step(2);

        // Masked store: upper half replaced, lower half kept
        sb.push_back('{m: 1'b1, ld: 1'b0, rd: 32'h0});
        xfer(1, 1'b1, 32'h68, 32'hA5A5_0000, 32'hFFFF_0000, 1);
        step(2);
        sb.push_back('{m: 1'b0, ld: 1'b1, rd: 32'hA5A5_5678});
        xfer(0, 1'b0, 32'h68, 32'h0, 32'h0, 1);
        step(2);
        sb.push_back('{m: 1'b1, ld: 1'b1, rd: 32'hA5A5_5678});
        xfer(1, 1'b0, 32'h68, 32'h0, 32'h0, 1);
        step(2);

        // Continuous contention for 12 cycles
        glog_m.delete();
        glog_c.delete();
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{m: 1'b0, ld: 1'b1, rd: 32'h1111_0000});
            sb.push_back('{m: 1'b1, ld: 1'b1, rd: 32'h2222_0004});
        end
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
        start = cyc;
        step(12);
        m0_req = 1'b0;
        m1_req = 1'b0;
        step(4);
        chk("rr_grant_count", 32'(glog_m.size()), 32'd4);
        for (int i = 0; i < 4 && i < glog_m.size(); i++) begin
            chk("rr_grant_owner", {31'd0, glog_m[i]}, 32'(i % 2));
            chk("rr_grant_cycle", 32'(glog_c[i] - start), 32'(1 + 3 * i));
        end

        // Reset during ACCESS of an m0 store
        dc = done_cnt;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF; m0_mask = 32'hFFFF_FFFF;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_gnt) begin
                got = 1'b1;
                break;
            end
        end
        chk("abort_gnt_seen", {31'd0, got}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_mem_we_drop", {31'd0, mem_we}, 32'd0);
        chk("abort_gnt_drop", {31'd0, m0_gnt}, 32'd0);
        m0_req = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);
        chk("abort_dmem_kept", dmem[4], 32'hCAFE_0010);
        chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
        chk("abort_m0_rdata_clr", m0_rdata, 32'd0);

        // rr back at 0 after reset: m0 wins the tie
        sb.push_back('{m: 1'b0, ld: 1'b1, rd: 32'h1111_0000});
        sb.push_back('{m: 1'b1, ld: 1'b1, rd: 32'h2222_0004});
        fork
            xfer(0, 1'b0, 32'h0, 32'h0, 32'h0, 1);
            xfer(1, 1'b0, 32'h4, 32'h0, 32'h0, 4);
        join
        step(2);

        // Idle: nothing moves for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_quiet", {27'd0, mem_we, m0_gnt, m0_done, m1_gnt, m1_done}, 32'd0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
